// File: rtl/game_pkg.sv
// Shared types and constants for the warships turn controller.
package game_pkg;

  typedef enum logic [3:0] {
    StClear    = 4'd0,
    StPlace    = 4'd1,
    StPlaceChk = 4'd2,
    StReady    = 4'd3,
    StAttack   = 4'd4,
    StAtkChk   = 4'd5,
    StSend     = 4'd6,
    StWaitRes  = 4'd7,
    StDefend   = 4'd8,
    StDefChk   = 4'd9,
    StAnswer   = 4'd10,
    StWin      = 4'd11,
    StLose     = 4'd12
  } state_e;

  localparam logic [1:0] CellEmpty = 2'd0;
  localparam logic [1:0] CellShip  = 2'd1;
  localparam logic [1:0] CellMiss  = 2'd2;
  localparam logic [1:0] CellHit   = 2'd3;

  localparam logic [7:0] NoCor = 8'hFF;

  localparam int unsigned GridNDefault = 10;

  function automatic logic cor_in_grid(input logic [7:0] cor, input int unsigned grid_n);
    return ({28'd0, cor[7:4]} < grid_n) && ({28'd0, cor[3:0]} < grid_n);
  endfunction

endpackage

// File: rtl/cor_click_det.sv
// Turns a coordinate level (8'hFF = none) into a one-cycle click pulse for in-grid cells.
module cor_click_det
  import game_pkg::*;
#(
  parameter int unsigned GridN = GridNDefault
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cor_i,
  output logic       click_o,
  output logic [7:0] cor_o
);

  logic [7:0] cor_q, cor_d;

  always_comb begin
    cor_d = cor_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cor_q <= NoCor;
    end else begin
      cor_q <= cor_d;
    end
  end

  always_comb begin
    click_o = (cor_q == NoCor) && (cor_i != NoCor) && cor_in_grid(cor_i, GridN);
    cor_o   = cor_i;
  end

endmodule

// File: rtl/game_ctrl.sv
// Warships turn sequencer: board clear, ship placement, attack/defend turns, win/lose.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHIP_CELLS   = 10,
  parameter int unsigned GRID_N       = GridNDefault,
  parameter bit          PLAYER_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [7:0] player_cor,
  input  logic [7:0] enemy_cor,
  output logic [7:0] pb_addr,
  output logic       pb_we,
  output logic [1:0] pb_wdata,
  input  logic [1:0] pb_rdata,
  output logic [7:0] eb_addr,
  output logic       eb_we,
  output logic [1:0] eb_wdata,
  input  logic [1:0] eb_rdata,
  output logic       tx_valid,
  output logic [7:0] tx_cor,
  input  logic       tx_ready,
  input  logic       rx_res_valid,
  input  logic       rx_res_hit,
  input  logic       rx_shot_valid,
  input  logic [7:0] rx_shot_cor,
  output logic       res_valid,
  output logic       res_hit,
  input  logic       res_ready,
  output logic [3:0] state,
  output logic       win,
  output logic       lose
);

  localparam int unsigned CntW = $clog2(SHIP_CELLS + 1);
  localparam logic [CntW-1:0] ShipCnt = CntW'(SHIP_CELLS);

  state_e          state_q, state_d;
  logic [7:0]      clr_addr_q, clr_addr_d;
  logic            rd_wait_q, rd_wait_d;
  logic            start_q, start_d;
  logic [7:0]      pb_addr_q, pb_addr_d, eb_addr_q, eb_addr_d;
  logic            pb_we_q, pb_we_d, eb_we_q, eb_we_d;
  logic [1:0]      pb_wdata_q, pb_wdata_d, eb_wdata_q, eb_wdata_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_cor_q, tx_cor_d;
  logic            res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic            win_q, win_d, lose_q, lose_d;
  logic [CntW-1:0] placed_q, placed_d, hits_q, hits_d, lost_q, lost_d;

  logic       p_click, e_click, start_rise;
  logic [7:0] p_cor, e_cor;

  cor_click_det #(.GridN(GRID_N)) u_player_det (
    .clk_i   (clk),
    .rst_i   (rst),
    .cor_i   (player_cor),
    .click_o (p_click),
    .cor_o   (p_cor)
  );

  cor_click_det #(.GridN(GRID_N)) u_enemy_det (
    .clk_i   (clk),
    .rst_i   (rst),
    .cor_i   (enemy_cor),
    .click_o (e_click),
    .cor_o   (e_cor)
  );

  always_comb begin
    start_d    = start_btn;
    start_rise = start_btn && !start_q;
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rd_wait_d   = 1'b0;
    pb_addr_d   = pb_addr_q;
    pb_we_d     = 1'b0;
    pb_wdata_d  = pb_wdata_q;
    eb_addr_d   = eb_addr_q;
    eb_we_d     = 1'b0;
    eb_wdata_d  = eb_wdata_q;
    tx_valid_d  = tx_valid_q;
    tx_cor_d    = tx_cor_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    win_d       = win_q;
    lose_d      = lose_q;
    placed_d    = placed_q;
    hits_d      = hits_q;
    lost_d      = lost_q;

    // Check states spend one cycle waiting for the board read data.
    unique case (state_q)
      StClear: begin
        pb_we_d    = 1'b1;
        eb_we_d    = 1'b1;
        pb_addr_d  = clr_addr_q;
        eb_addr_d  = clr_addr_q;
        pb_wdata_d = CellEmpty;
        eb_wdata_d = CellEmpty;
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) begin
          placed_d = '0;
          hits_d   = '0;
          lost_d   = '0;
          win_d    = 1'b0;
          lose_d   = 1'b0;
          state_d  = StPlace;
        end
      end
      StPlace: begin
        if (p_click) begin
          pb_addr_d = p_cor;
          state_d   = StPlaceChk;
        end
      end
      StPlaceChk: begin
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          if (pb_rdata == CellEmpty) begin
            pb_we_d    = 1'b1;
            pb_wdata_d = CellShip;
            placed_d   = placed_q + CntW'(1);
          end
          state_d = (placed_d == ShipCnt) ? StReady : StPlace;
        end
      end
      StReady: begin
        if (start_rise) state_d = PLAYER_FIRST ? StAttack : StDefend;
      end
      StAttack: begin
        if (e_click) begin
          eb_addr_d = e_cor;
          state_d   = StAtkChk;
        end
      end
      StAtkChk: begin
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else if (eb_rdata != CellEmpty) begin
          state_d = StAttack;
        end else begin
          tx_cor_d   = eb_addr_q;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StWaitRes;
        end
      end
      StWaitRes: begin
        if (rx_res_valid) begin
          eb_we_d    = 1'b1;
          eb_addr_d  = tx_cor_q;
          eb_wdata_d = rx_res_hit ? CellHit : CellMiss;
          if (rx_res_hit) hits_d = hits_q + CntW'(1);
          if (hits_d == ShipCnt) begin
            win_d   = 1'b1;
            state_d = StWin;
          end else begin
            state_d = StDefend;
          end
        end
      end
      StDefend: begin
        if (rx_shot_valid) begin
          if (cor_in_grid(rx_shot_cor, GRID_N)) begin
            pb_addr_d = rx_shot_cor;
            state_d   = StDefChk;
          end else begin
            res_hit_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = StAnswer;
          end
        end
      end
      StDefChk: begin
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          case (pb_rdata)
            CellShip: begin
              pb_we_d    = 1'b1;
              pb_wdata_d = CellHit;
              res_hit_d  = 1'b1;
              lost_d     = lost_q + CntW'(1);
            end
            CellHit: res_hit_d = 1'b1;
            default: begin
              pb_we_d    = 1'b1;
              pb_wdata_d = CellMiss;
              res_hit_d  = 1'b0;
            end
          endcase
          res_valid_d = 1'b1;
          state_d     = StAnswer;
        end
      end
      StAnswer: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (lost_q == ShipCnt) begin
            lose_d  = 1'b1;
            state_d = StLose;
          end else begin
            state_d = StAttack;
          end
        end
      end
      StWin, StLose: begin
        if (start_rise) begin
          clr_addr_d = 8'd0;
          placed_d   = '0;
          hits_d     = '0;
          lost_d     = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          state_d    = StClear;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StClear;
      clr_addr_q  <= 8'd0;
      rd_wait_q   <= 1'b0;
      start_q     <= 1'b0;
      pb_addr_q   <= 8'd0;
      pb_we_q     <= 1'b0;
      pb_wdata_q  <= 2'd0;
      eb_addr_q   <= 8'd0;
      eb_we_q     <= 1'b0;
      eb_wdata_q  <= 2'd0;
      tx_valid_q  <= 1'b0;
      tx_cor_q    <= NoCor;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      placed_q    <= '0;
      hits_q      <= '0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rd_wait_q   <= rd_wait_d;
      start_q     <= start_d;
      pb_addr_q   <= pb_addr_d;
      pb_we_q     <= pb_we_d;
      pb_wdata_q  <= pb_wdata_d;
      eb_addr_q   <= eb_addr_d;
      eb_we_q     <= eb_we_d;
      eb_wdata_q  <= eb_wdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_cor_q    <= tx_cor_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      placed_q    <= placed_d;
      hits_q      <= hits_d;
      lost_q      <= lost_d;
    end
  end

  assign state     = state_q;
  assign pb_addr   = pb_addr_q;
  assign pb_we     = pb_we_q;
  assign pb_wdata  = pb_wdata_q;
  assign eb_addr   = eb_addr_q;
  assign eb_we     = eb_we_q;
  assign eb_wdata  = eb_wdata_q;
  assign tx_valid  = tx_valid_q;
  assign tx_cor    = tx_cor_q;
  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: board models, expected write/shot/answer queues.
module tb_game_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic [7:0] player_cor, enemy_cor;
  logic [7:0] pb_addr, eb_addr;
  logic       pb_we, eb_we;
  logic [1:0] pb_wdata, eb_wdata;
  logic [1:0] pb_rdata, eb_rdata;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_cor;
  logic       rx_res_valid, rx_res_hit, rx_shot_valid;
  logic [7:0] rx_shot_cor;
  logic       res_valid, res_hit, res_ready;
  logic [3:0] state;
  logic       win, lose;

  logic [1:0] pb_mem [256];
  logic [1:0] eb_mem [256];

  logic [9:0] pb_q  [$];
  logic [9:0] eb_q  [$];
  logic [7:0] tx_q  [$];
  logic       res_q [$];
  logic       mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  game_ctrl #(.SHIP_CELLS(10), .GRID_N(10), .PLAYER_FIRST(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_btn     (start_btn),
    .player_cor    (player_cor),
    .enemy_cor     (enemy_cor),
    .pb_addr       (pb_addr),
    .pb_we         (pb_we),
    .pb_wdata      (pb_wdata),
    .pb_rdata      (pb_rdata),
    .eb_addr       (eb_addr),
    .eb_we         (eb_we),
    .eb_wdata      (eb_wdata),
    .eb_rdata      (eb_rdata),
    .tx_valid      (tx_valid),
    .tx_cor        (tx_cor),
    .tx_ready      (tx_ready),
    .rx_res_valid  (rx_res_valid),
    .rx_res_hit    (rx_res_hit),
    .rx_shot_valid (rx_shot_valid),
    .rx_shot_cor   (rx_shot_cor),
    .res_valid     (res_valid),
    .res_hit       (res_hit),
    .res_ready     (res_ready),
    .state         (state),
    .win           (win),
    .lose          (lose)
  );

  // Board memories with one-cycle read latency.
  always @(posedge clk) begin
    if (pb_we) pb_mem[pb_addr] <= pb_wdata;
    if (eb_we) eb_mem[eb_addr] <= eb_wdata;
    pb_rdata <= pb_mem[pb_addr];
    eb_rdata <= eb_mem[eb_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Every board write and handshake must match the head of its expectation queue.
  always @(negedge clk) begin
    logic [10:0] e_pb, e_eb;
    logic [8:0]  e_tx;
    logic [1:0]  e_res;
    if (mon_en) begin
      if (pb_we) begin
        e_pb = '0;
        if (pb_q.size() > 0) e_pb = {1'b1, pb_q.pop_front()};
        check_eq("pb_write", {21'd0, 1'b1, pb_addr, pb_wdata}, {21'd0, e_pb});
      end
      if (eb_we) begin
        e_eb = '0;
        if (eb_q.size() > 0) e_eb = {1'b1, eb_q.pop_front()};
        check_eq("eb_write", {21'd0, 1'b1, eb_addr, eb_wdata}, {21'd0, e_eb});
      end
      if (tx_valid && tx_ready) begin
        e_tx = '0;
        if (tx_q.size() > 0) e_tx = {1'b1, tx_q.pop_front()};
        check_eq("tx_shot", {23'd0, 1'b1, tx_cor}, {23'd0, e_tx});
      end
      if (res_valid && res_ready) begin
        e_res = '0;
        if (res_q.size() > 0) e_res = {1'b1, res_q.pop_front()};
        check_eq("res_answer", {30'd0, 1'b1, res_hit}, {30'd0, e_res});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input state_e s);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == s) break;
    end
    check_eq(tag, state, s);
  endtask

  task automatic drain(input string tag);
    tick(3);
    check_eq(tag, pb_q.size() + eb_q.size() + tx_q.size() + res_q.size(), 0);
  endtask

  task automatic sweep_check(input string tag);
    int n = 0;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pb_we || eb_we) begin
        if (!(pb_we && eb_we && pb_addr == n[7:0] && eb_addr == n[7:0] &&
              pb_wdata == CellEmpty && eb_wdata == CellEmpty)) bad++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    check_eq({tag, "_cnt"}, n, 256);
    check_eq({tag, "_bad"}, bad, 0);
    check_eq({tag, "_state"}, state, StPlace);
  endtask

  task automatic click_player(input logic [7:0] c);
    player_cor = c;
    tick(1);
    player_cor = NoCor;
    tick(5);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    tick(1);
  endtask

  task automatic place_all(input string tag);
    for (int i = 0; i < 10; i++) begin
      pb_q.push_back({8'(i), CellShip});
      click_player(8'(i));
    end
    drain({tag, "_drain"});
    check_eq({tag, "_ready"}, state, StReady);
  endtask

  task automatic do_attack(input logic [7:0] c, input logic hit, input state_e nxt);
    tx_ready = 1'b1;
    tx_q.push_back(c);
    tick(1);
    enemy_cor = c;
    tick(1);
    enemy_cor = NoCor;
    wait_state("atk_wait_res", StWaitRes);
    eb_q.push_back({c, hit ? CellHit : CellMiss});
    tick(1);
    rx_res_valid = 1'b1;
    rx_res_hit   = hit;
    tick(1);
    rx_res_valid = 1'b0;
    rx_res_hit   = 1'b0;
    wait_state("atk_next", nxt);
  endtask

  task automatic do_defend(input logic [7:0] c, input logic exp_hit, input logic exp_wr,
                           input logic [1:0] wdata, input state_e nxt);
    res_ready = 1'b1;
    if (exp_wr) pb_q.push_back({c, wdata});
    res_q.push_back(exp_hit);
    tick(1);
    rx_shot_valid = 1'b1;
    rx_shot_cor   = c;
    tick(1);
    rx_shot_valid = 1'b0;
    rx_shot_cor   = 8'h00;
    wait_state("def_next", nxt);
  endtask

  initial begin
    rst = 1'b1;
    start_btn = 1'b0;
    player_cor = NoCor;
    enemy_cor = NoCor;
    tx_ready = 1'b0;
    rx_res_valid = 1'b0;
    rx_res_hit = 1'b0;
    rx_shot_valid = 1'b0;
    rx_shot_cor = 8'h00;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", state, StClear);
    check_eq("rst_we", {30'd0, pb_we, eb_we}, 0);
    check_eq("rst_addr", {pb_addr, eb_addr}, 0);
    check_eq("rst_tx_cor", tx_cor, 8'hFF);
    check_eq("rst_flags", {28'd0, tx_valid, res_valid, win, lose}, 0);
    check_eq("rst_res_hit", res_hit, 0);
    rst = 1'b0;
    sweep_check("sweep");
    mon_en = 1'b1;

    // Placement: duplicate, out-of-grid, held level, enemy click and start all ignored.
    pb_q.push_back({8'h00, CellShip});
    click_player(8'h00);
    click_player(8'h00);
    click_player(8'hB3);
    check_eq("place_ignore_b3", state, StPlace);
    enemy_cor = 8'h20;
    start_btn = 1'b1;
    tick(1);
    enemy_cor = NoCor;
    start_btn = 1'b0;
    tick(4);
    check_eq("place_ignore_start", state, StPlace);
    pb_q.push_back({8'h01, CellShip});
    player_cor = 8'h01;
    tick(50);
    player_cor = NoCor;
    tick(5);
    for (int i = 2; i < 10; i++) begin
      pb_q.push_back({8'(i), CellShip});
      click_player(8'(i));
    end
    drain("place_drain");
    check_eq("place_ready", state, StReady);

    press_start();
    check_eq("start_attack", state, StAttack);

    // Shot held by backpressure.
    tx_q.push_back(8'h45);
    enemy_cor = 8'h45;
    tick(1);
    enemy_cor = NoCor;
    wait_state("send_reached", StSend);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("tx_hold_valid", tx_valid, 1);
      check_eq("tx_hold_cor", tx_cor, 8'h45);
    end
    tick(1);
    tx_ready = 1'b1;
    wait_state("wait_res", StWaitRes);
    eb_q.push_back({8'h45, CellHit});
    tick(1);
    rx_res_valid = 1'b1;
    rx_res_hit = 1'b1;
    tick(1);
    rx_res_valid = 1'b0;
    rx_res_hit = 1'b0;
    wait_state("to_defend", StDefend);

    // Answer held until accepted.
    pb_q.push_back({8'h03, CellHit});
    res_q.push_back(1'b1);
    tick(1);
    rx_shot_valid = 1'b1;
    rx_shot_cor = 8'h03;
    tick(1);
    rx_shot_valid = 1'b0;
    wait_state("answer_reached", StAnswer);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("res_hold", {30'd0, res_valid, res_hit}, 2'b11);
    end
    tick(1);
    res_ready = 1'b1;
    wait_state("answer_done", StAttack);

    do_attack(8'h46, 1'b0, StDefend);
    do_defend(8'h03, 1'b1, 1'b0, CellHit, StAttack);

    enemy_cor = 8'h45;
    tick(1);
    enemy_cor = NoCor;
    tick(5);
    check_eq("reshot_state", state, StAttack);
    check_eq("reshot_no_tx", tx_valid, 0);

    do_attack(8'h47, 1'b0, StDefend);
    do_defend(8'h77, 1'b0, 1'b1, CellMiss, StAttack);
    do_attack(8'h48, 1'b0, StDefend);
    do_defend(8'hA0, 1'b0, 1'b0, CellMiss, StAttack);
    for (int k = 0; k < 9; k++) begin
      do_attack(8'h50 + 8'(k), 1'b1, (k == 8) ? StWin : StDefend);
      if (k < 8) do_defend(8'h80 + 8'(k), 1'b0, 1'b1, CellMiss, StAttack);
    end
    drain("game1_drain");
    check_eq("win_flags", {30'd0, win, lose}, 2'b10);

    mon_en = 1'b0;
    start_btn = 1'b1;
    tick(1);
    check_eq("win_to_clear", state, StClear);
    check_eq("win_cleared", win, 0);
    start_btn = 1'b0;
    sweep_check("sweep2");
    mon_en = 1'b1;

    // Second game: every opponent shot lands, ending in LOSE.
    place_all("place2");
    press_start();
    check_eq("start2_attack", state, StAttack);
    for (int k = 0; k < 10; k++) begin
      do_attack(8'h60 + 8'(k), 1'b0, StDefend);
      do_defend(8'(k), 1'b1, 1'b1, CellHit, (k == 9) ? StLose : StAttack);
    end
    drain("game2_drain");
    check_eq("lose_flags", {30'd0, win, lose}, 2'b01);
    enemy_cor = 8'h12;
    tick(1);
    enemy_cor = NoCor;
    tick(3);
    check_eq("lose_holds", state, StLose);

    // Third game: asynchronous reset while a shot is pending.
    mon_en = 1'b0;
    press_start();
    sweep_check("sweep3");
    mon_en = 1'b1;
    place_all("place3");
    press_start();
    tx_ready = 1'b0;
    enemy_cor = 8'h11;
    tick(1);
    enemy_cor = NoCor;
    wait_state("send3_reached", StSend);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_tx_valid", tx_valid, 0);
    check_eq("arst_state", state, StClear);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("sweep_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Turn-sequencing controller for the warships game. Consumes the registered start-button level and the player/enemy board cell coordinates from the mouse controller, where 8'hFF means no click. It owns the read/write ports of both board memories and the shot/result handshake with the opponent link. It steps the game through board clear, ship placement, alternating attack/defend turns and win/lose.

## Interface
- SHIP_CELLS, default 10: ship cells each player places; also the hit count that ends the game.
- GRID_N, default 10: valid cell range per nibble is 0..GRID_N-1.
- PLAYER_FIRST, default 1: 1 = local player attacks first after start.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_btn  in  1  start button level, high while held
- player_cor  in  8  {x[3:0],y[3:0]} on own board, 8'hFF = none
- enemy_cor  in  8  same encoding, enemy board
- pb_addr / pb_we / pb_wdata  out  8/1/2  player board port
- pb_rdata  in  2  player board read data, 1-cycle latency
- eb_addr / eb_we / eb_wdata  out  8/1/2  enemy board port
- eb_rdata  in  2  enemy board read data, 1-cycle latency
- tx_valid / tx_cor  out  1/8  our shot to link; tx_ready in 1
- rx_res_valid / rx_res_hit  in  1/1  link result of our shot, 1-cycle pulse
- rx_shot_valid / rx_shot_cor  in  1/8  opponent shot, 1-cycle pulse
- res_valid / res_hit  out  1/1  our answer to opponent shot; res_ready in 1
- state  out  4  current state, for display
- win / lose  out  1/1  terminal flags

## Operation
- Cell encoding: EMPTY=0, SHIP=1, MISS=2, HIT=3.
- Click detection:
  - A click is a transition of a coordinate input from 8'hFF to a non-FF value.
  - Holding the button produces exactly one click.
  - A click with either nibble ≥ GRID_N is ignored.
- CLEAR:
  - Entered on reset, and from WIN/LOSE on a start_btn rising edge.
  - Sweeps addresses 0..255, writing EMPTY to both boards, one address per cycle (256 cycles).
  - Clears all counters, win and lose, then goes to PLACE.
- PLACE:
  - A player_cor click drives pb_addr and goes to PLACE_CHK.
  - PLACE_CHK: if pb_rdata==EMPTY, write SHIP and increment placed; otherwise no write.
  - If placed==SHIP_CELLS, go to READY; otherwise return to PLACE.
  - enemy_cor and start_btn are ignored in PLACE.
- READY: a start_btn rising edge goes to ATTACK if PLAYER_FIRST, else DEFEND.
- ATTACK:
  - An enemy_cor click drives eb_addr and goes to ATK_CHK.
  - ATK_CHK: if eb_rdata≠EMPTY, return to ATTACK (re-shot rejected); otherwise latch the coordinate and go to SEND.
- SEND: tx_valid=1 with tx_cor stable until tx_valid&&tx_ready, then WAIT_RES.
- WAIT_RES:
  - On rx_res_valid, write HIT or MISS to the enemy board at the latched coordinate.
  - On HIT, increment hits. If hits==SHIP_CELLS go to WIN, else DEFEND.
- DEFEND:
  - On rx_shot_valid, latch rx_shot_cor, drive pb_addr and go to DEF_CHK.
  - An out-of-grid opponent coordinate is answered as a miss with no board write.
- DEF_CHK:
  - pb_rdata==SHIP: write HIT, set res_hit=1, increment lost.
  - pb_rdata==HIT: set res_hit=1, no write, no count.
  - Otherwise: write MISS, set res_hit=0.
  - Go to ANSWER.
- ANSWER:
  - res_valid=1 until res_ready.
  - Then go to LOSE if lost==SHIP_CELLS, else ATTACK.
- WIN / LOSE: hold win=1 or lose=1. All inputs are ignored except a start_btn rising edge, which goes to CLEAR.
- Link pulses arriving in any other state are dropped.

## Timing
- Reset values:
  - state=CLEAR, clear address=0.
  - All we, tx_valid, res_valid, win, lose = 0.
  - Addresses = 0, wdata = 0, tx_cor = 8'hFF, res_hit = 0.
- All outputs are registered.
- Click-to-write latency in PLACE is 3 cycles: detect, read, write.
- tx_valid and res_valid are held stable until accepted; tx_cor must not change while tx_valid=1.
- Edge detectors (coordinate and start_btn) keep sampling in every state, so a level held across a state change never creates a click.
- An asynchronous reset mid-game returns to CLEAR and restarts the full 256-address sweep.

## Structure
- Package game_pkg holds:
  - the state enum
  - cell encodings EMPTY/SHIP/MISS/HIT
  - NO_COR = 8'hFF
  - default GRID_N
- Sub-module cor_click_det:
  - Registers an 8-bit coordinate and outputs a 1-cycle click pulse plus the valid coordinate.
  - Instantiated twice, one per board.
- Start-button edge detection stays inline.

## Test plan
- Reset, then idle: 256 cycles of eb_we=pb_we=1 with wdata=0 and addresses 0..255, then state=PLACE.
- Place cells 0x00..0x09:
  - Ten SHIP writes, then READY.
  - Clicking 0x00 twice writes once.
  - Click 0xB3 is ignored.
  - player_cor held for 50 cycles writes once.
- Attack:
  - Start pressed, enemy click 0x45, hold tx_ready=0 for 5 cycles: tx_valid and tx_cor=0x45 stay stable.
  - rx_res_hit=1 writes HIT to eb at 0x45, then DEFEND.
- Defend:
  - rx_shot_cor=0x03 on a SHIP cell: HIT written, res_valid with res_hit=1 until res_ready.
  - Repeat shot at 0x03 answers hit with no count.
  - Shot at 0x77 answers miss and writes MISS.
- Endgame:
  - SHIP_CELLS enemy hits reach WIN with win=1.
  - Start pressed in WIN goes to CLEAR with win=0.
  - A separate run with SHIP_CELLS own losses asserts lose.
- Assert rst during SEND: tx_valid drops immediately and state=CLEAR.
